// File: rtl/stim_pattern_gen.sv
// stim_pattern_gen: on-chip stimulus source for filter DUTs.
// Produces zero, impulse, square, ramp and pseudo-noise sample streams, one
// sample per enable strobe, with mode/period latched only at frame boundaries.
// Optional build macro STIM_GEN_OFFSET_EN adds a saturating dc_offset input.
module stim_pattern_gen #(
  parameter int          DATA_W    = 18,
  parameter int          CNT_W     = 8,
  parameter logic [17:0] LFSR_SEED = 18'h2AAAA
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [2:0]               mode,
  input  logic [CNT_W-1:0]         period,
  input  logic signed [DATA_W-1:0] amplitude,
`ifdef STIM_GEN_OFFSET_EN
  input  logic signed [DATA_W-1:0] dc_offset,
`endif
  output logic signed [DATA_W-1:0] x_out,
  output logic                     x_valid,
  output logic                     frame_start
);

  typedef enum logic [2:0] {
    MODE_ZERO    = 3'd0,
    MODE_IMPULSE = 3'd1,
    MODE_SQUARE  = 3'd2,
    MODE_RAMP    = 3'd3,
    MODE_NOISE   = 3'd4
  } mode_t;

  localparam int CNT_W1 = CNT_W + 1;
  localparam logic signed [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  // Clamp a one-bit-wider sum back into the DATA_W two's complement range.
  function automatic logic signed [DATA_W-1:0] sat_wide(input logic signed [DATA_W:0] v);
    if (v[DATA_W] != v[DATA_W-1])
      sat_wide = v[DATA_W] ? MIN_VAL : MAX_VAL;
    else
      sat_wide = v[DATA_W-1:0];
  endfunction

  // Saturating signed add of two DATA_W values.
  function automatic logic signed [DATA_W-1:0] sat_add(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] s;
    s = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
    sat_add = sat_wide(s);
  endfunction

  // Architectural state
  logic [CNT_W-1:0]         count_reg, count_next;
  logic [2:0]               act_mode_reg;
  logic [CNT_W-1:0]         act_period_reg;
  logic signed [DATA_W-1:0] ramp_acc_reg, ramp_next;
  logic [17:0]              lfsr_reg, lfsr_next;
  logic signed [DATA_W-1:0] x_out_reg;
  logic                     x_valid_reg;
  logic                     frame_start_reg;

  // Per-strobe working values
  logic                     boundary;
  logic [2:0]               eff_mode;
  logic [CNT_W-1:0]         eff_period;
  logic signed [DATA_W-1:0] eff_ramp;
  logic [CNT_W1-1:0]        half_period;
  logic signed [DATA_W-1:0] neg_amp;
  logic signed [DATA_W-1:0] pattern;
  logic signed [DATA_W-1:0] sample;

  // Resolve the settings used by this strobe and compute the pattern sample.
  // At a frame boundary the live inputs are used directly so the first sample
  // of each frame already reflects the new mode/period.
  always_comb begin
    boundary    = (count_reg == '0);
    eff_mode    = boundary ? mode : act_mode_reg;
    eff_period  = act_period_reg;
    if (boundary)
      eff_period = (period == '0) ? CNT_W'(1) : period;
    eff_ramp    = boundary ? '0 : ramp_acc_reg;
    // ceil(P/2): number of leading high samples in a square frame
    half_period = ({1'b0, eff_period} + CNT_W1'(1)) >> 1;
    // -amplitude, with the most negative value mapped to +max
    neg_amp     = (amplitude == MIN_VAL) ? MAX_VAL : -amplitude;

    pattern = '0;
    case (eff_mode)
      MODE_IMPULSE: pattern = boundary ? amplitude : '0;
      MODE_SQUARE:  pattern = ({1'b0, count_reg} < half_period) ? amplitude : neg_amp;
      MODE_RAMP:    pattern = eff_ramp;
      MODE_NOISE:   pattern = lfsr_reg[17 -: DATA_W];
      default:      pattern = '0;
    endcase

    // Ramp accumulator only advances in ramp mode; boundaries clear it.
    ramp_next = eff_ramp;
    if (eff_mode == MODE_RAMP)
      ramp_next = sat_add(eff_ramp, amplitude);

    count_next = (count_reg == eff_period - CNT_W'(1)) ? '0 : count_reg + CNT_W'(1);

    // Fibonacci LFSR, x^18 + x^11 + 1
    lfsr_next = {lfsr_reg[16:0], lfsr_reg[17] ^ lfsr_reg[10]};

`ifdef STIM_GEN_OFFSET_EN
    sample = sat_add(pattern, dc_offset);
`else
    sample = pattern;
`endif
  end

  // Frame/pattern state advances once per enable strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg      <= '0;
      act_mode_reg   <= MODE_ZERO;
      act_period_reg <= CNT_W'(1);
      ramp_acc_reg   <= '0;
      lfsr_reg       <= LFSR_SEED;
    end else if (enable) begin
      count_reg      <= count_next;
      act_mode_reg   <= eff_mode;
      act_period_reg <= eff_period;
      ramp_acc_reg   <= ramp_next;
      lfsr_reg       <= lfsr_next;
    end
  end

  // Output register: sample held between strobes, valid/frame flags pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_out_reg       <= '0;
      x_valid_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      x_valid_reg     <= enable;
      frame_start_reg <= enable & boundary;
      if (enable)
        x_out_reg <= sample;
    end
  end

  assign x_out       = x_out_reg;
  assign x_valid     = x_valid_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Testbench for stim_pattern_gen: table-driven vectors plus hand-written
// sequences for noise, asynchronous reset and optional dc offset.
module tb_stim_pattern_gen;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [2:0]         mode;
  logic [7:0]         period;
  logic signed [17:0] amplitude;
`ifdef STIM_GEN_OFFSET_EN
  logic signed [17:0] dc_offset;
`endif
  logic signed [17:0] x_out;
  logic               x_valid;
  logic               frame_start;

  stim_pattern_gen #(.DATA_W(18), .CNT_W(8), .LFSR_SEED(18'h2AAAA)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .period      (period),
    .amplitude   (amplitude),
`ifdef STIM_GEN_OFFSET_EN
    .dc_offset   (dc_offset),
`endif
    .x_out       (x_out),
    .x_valid     (x_valid),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] m;
    int         p;
    int         a;
    int         ex;
    logic       fs;
  } vec_t;

  typedef struct {
    int   x;
    logic fs;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_x  = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  function automatic void add(input logic en, input logic [2:0] m, input int p,
                              input int a, input int ex, input logic fs);
    vec_t v;
    v.en = en; v.m = m; v.p = p; v.a = a; v.ex = ex; v.fs = fs;
    vecs.push_back(v);
  endfunction

  // One clock: drive at negedge, score one cycle later (#1 after posedge).
  task automatic step(input logic en, input logic [2:0] m, input int p, input int a,
                      input int ex, input logic efs, input string tag);
    exp_t e;
    exp_t ne;
    @(negedge clk);
    enable    = en;
    mode      = m;
    period    = p[7:0];
    amplitude = a[17:0];
    if (en) begin
      ne.x  = ex;
      ne.fs = efs;
      sb_q.push_back(ne);
    end
    @(posedge clk);
    #1;
    if (en) begin
      e = sb_q.pop_front();
      chk({tag, ".x_valid"}, int'(x_valid), 1);
      chk({tag, ".x_out"}, int'(x_out), e.x);
      chk({tag, ".frame_start"}, int'(frame_start), int'(e.fs));
      last_x = e.x;
    end else begin
      chk({tag, ".idle_valid"}, int'(x_valid), 0);
      chk({tag, ".held_x_out"}, int'(x_out), last_x);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    last_x = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] model;
    int j;

    reset = 1'b1; enable = 1'b0; mode = 3'd0; period = 8'd1; amplitude = '0;
`ifdef STIM_GEN_OFFSET_EN
    dc_offset = '0;
`endif

    // Impulse, P=21, full-scale amplitude, with an idle gap mid-frame
    for (int i = 0; i < 63; i++) begin
      if (i == 30) begin
        add(1'b0, 3'd1, 21, 131071, 0, 1'b0);
        add(1'b0, 3'd1, 21, 131071, 0, 1'b0);
      end
      add(1'b1, 3'd1, 21, 131071, (i % 21 == 0) ? 131071 : 0, (i % 21) == 0);
    end
    // Square P=5, then a frame where mode switches to impulse at sample 2
    for (int i = 0; i < 15; i++) begin
      j = i % 5;
      add(1'b1, (i >= 12) ? 3'd1 : 3'd2, 5, 1000, (j < 3) ? 1000 : -1000, j == 0);
    end
    for (int i = 0; i < 5; i++)
      add(1'b1, 3'd1, 5, 1000, (i == 0) ? 1000 : 0, i == 0);
    // Ramp P=4 with positive saturation, two frames
    for (int i = 0; i < 8; i++) begin
      j = i % 4;
      add(1'b1, 3'd3, 4, 100000, (j == 0) ? 0 : (j == 1) ? 100000 : 131071, j == 0);
    end
    // Ramp P=3 with negative saturation
    add(1'b1, 3'd3, 3, -100000, 0, 1'b1);
    add(1'b1, 3'd3, 3, -100000, -100000, 1'b0);
    add(1'b1, 3'd3, 3, -100000, -131072, 1'b0);
    // Period 0 behaves as 1: continuous impulse
    for (int i = 0; i < 5; i++)
      add(1'b1, 3'd1, 0, -5, -5, 1'b1);
    // Square with the most negative amplitude, P=3 (ceil = 2)
    add(1'b1, 3'd2, 3, -131072, -131072, 1'b1);
    add(1'b1, 3'd2, 3, -131072, -131072, 1'b0);
    add(1'b1, 3'd2, 3, -131072, 131071, 1'b0);
    // Square P=4 (ceil = 2)
    add(1'b1, 3'd2, 4, 7, 7, 1'b1);
    add(1'b1, 3'd2, 4, 7, 7, 1'b0);
    add(1'b1, 3'd2, 4, 7, -7, 1'b0);
    add(1'b1, 3'd2, 4, 7, -7, 1'b0);
    // Square P=1: always high
    for (int i = 0; i < 3; i++)
      add(1'b1, 3'd2, 1, 9, 9, 1'b1);
    // Reserved mode 6 behaves as zero
    add(1'b1, 3'd6, 2, 123, 0, 1'b1);
    add(1'b1, 3'd6, 2, 123, 0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.x_out", int'(x_out), 0);
    chk("reset.x_valid", int'(x_valid), 0);
    chk("reset.frame_start", int'(frame_start), 0);
    reset = 1'b0;

    foreach (vecs[i])
      step(vecs[i].en, vecs[i].m, vecs[i].p, vecs[i].a, vecs[i].ex, vecs[i].fs,
           $sformatf("vec%0d", i));

`ifdef STIM_GEN_OFFSET_EN
    // Saturating dc offset, sampled on every enable
    dc_offset = 18'sd500;
    step(1'b1, 3'd1, 0, 131000, 131071, 1'b1, "offset_sat0");
    step(1'b1, 3'd1, 0, 131000, 131071, 1'b1, "offset_sat1");
    step(1'b1, 3'd1, 0, -5, 495, 1'b1, "offset_add");
    dc_offset = '0;
`endif

    // Noise, enable every 3rd cycle, against a reference LFSR from the seed
    do_reset();
    model = 18'h2AAAA;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 3'd4, 8, 0, int'($signed(model)), (k % 8) == 0, $sformatf("noise%0d", k));
      model = {model[16:0], model[17] ^ model[10]};
      step(1'b0, 3'd4, 8, 0, 0, 1'b0, $sformatf("noise%0d_gap1", k));
      step(1'b0, 3'd4, 8, 0, 0, 1'b0, $sformatf("noise%0d_gap2", k));
    end

    // Asynchronous reset mid-frame while x_out is non-zero and x_valid high
    do_reset();
    for (int i = 0; i < 7; i++)
      step(1'b1, 3'd2, 21, 55, 55, i == 0, $sformatf("prereset%0d", i));
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset.x_out", int'(x_out), 0);
    chk("async_reset.x_valid", int'(x_valid), 0);
    chk("async_reset.frame_start", int'(frame_start), 0);
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b0;
    sb_q.delete();
    last_x = 0;
    step(1'b1, 3'd1, 21, 77, 77, 1'b1, "post_reset0");
    step(1'b1, 3'd1, 21, 77, 0, 1'b0, "post_reset1");
    step(1'b0, 3'd1, 21, 77, 0, 1'b0, "post_reset_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
